vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parameterised VGA raster timing generator for 640x480@60 Hz (25.175 MHz pixel clock, 25 MHz nominal).
- Produces pixel coordinates, display-enable, sync pulses and frame/line strobes for the pixel-colour stage, which registers RGB one cycle after the coordinates.
- Delays the sync outputs by one cycle so they arrive at the TinyVGA PMOD aligned with the registered RGB.
- Includes a pixel-enable input for running from a 2x clock, and a frame counter for animation logic.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines
- SYNC_ACTIVE, 0, logic level of asserted hsync/vsync (0 = active-low)

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset, synchronous, active-low
- pix_en  input  1  advance enable; counters step only when 1
- hpos  output  10  current column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- display_on  output  1  1 when hpos<H_DISPLAY and vpos<V_DISPLAY
- hsync  output  1  horizontal sync, one-cycle delayed
- vsync  output  1  vertical sync, one-cycle delayed
- line_start  output  1  one-cycle pulse when hpos==0 and pix_en
- frame_start  output  1  one-cycle pulse when hpos==0, vpos==0 and pix_en
- frame_count  output  8  completed-frame counter, wraps

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset (rst_n=0 at a clk edge):
  - hpos=0, vpos=0, frame_count=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - With pix_en=1, line_start and frame_start are 1 on the first cycle after reset, because hpos=vpos=0.
- Counters, updated on a clk edge with pix_en=1:
  - hpos==H_TOTAL-1 -> hpos=0; otherwise hpos+1.
  - When hpos wraps: vpos==V_TOTAL-1 -> vpos=0 and frame_count+1 (mod 256); otherwise vpos+1.
  - pix_en=0 -> all counters and registered outputs hold their value.
- Counters never exceed their totals. Any out-of-range value (not reachable in normal operation) wraps to 0 on the next advance.
- display_on, line_start and frame_start are combinational from the current counters and pix_en, with zero latency relative to hpos/vpos.
- Sync decode, combinational:
  - hs_c = (H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC), i.e. 656..751.
  - vs_c = (V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC), i.e. 490..491.
- Sync outputs are registered when pix_en=1:
  - hsync <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE; vsync is formed the same way from vs_c.
  - Latency is exactly 1 pix_en cycle after the coordinates. This matches the downstream RGB register.
- vsync spans full lines. Its registered edges occur one pixel after the hpos 799->0 wrap into vpos 490 and into vpos 492.
- Reset mid-frame: the next cycle shows hpos=0, vpos=0 and the syncs deasserted. No partial-state residue.
- Widths: 10-bit counters support H_TOTAL and V_TOTAL up to 1024. Totals above 1024 are illegal parameterisation. An elaboration-time check is required.

Test Plan:
- Reset, then pix_en=1 held for 800 cycles:
  - hpos counts 0..799 and wraps to 0; vpos steps 0->1.
  - line_start is high at cycles 0 and 800.
  - frame_start is high only at cycle 0.
- hsync timing: hsync is low on the cycles following hpos=656..751 (visible at hpos=657..752) and high elsewhere; pulse width is 96 cycles.
- Full frame (420000 cycles):
  - vsync is low for exactly 1600 cycles, starting 1 cycle after (hpos=0, vpos=490).
  - display_on is high for exactly 307200 cycles.
  - frame_count goes 0->1, and frame_start is seen again at cycle 420000.
- pix_en toggling 1,0,1,0:
  - hpos advances once per two clk cycles.
  - hsync/vsync hold during pix_en=0 cycles.
  - line_start never fires with pix_en=0.
- Reset asserted at hpos=700, vpos=300 -> next cycle hpos=0, vpos=0, hsync=vsync=1, frame_count=0.
- frame_count wrap: run 256 frames (or force-preload 255) -> frame_count reads 0 after the next vpos wrap.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (default 640x480@60) with pixel enable,
// syncs delayed one cycle to line up with registered RGB, and a frame counter.
module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG = H_DISPLAY + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_DISPLAY + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [7:0] fc_q, fc_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       h_wrap, v_wrap, hs_c, vs_c;

  // >= rather than == so any out-of-range count falls back to 0 on the next advance
  always_comb begin
    h_wrap = h_q >= H_LAST;
    v_wrap = v_q >= V_LAST;
    hs_c   = int'(h_q) >= HS_BEG && int'(h_q) < HS_END;
    vs_c   = int'(v_q) >= VS_BEG && int'(v_q) < VS_END;
    h_d    = h_wrap ? '0 : h_q + 10'd1;
    v_d    = !h_wrap ? v_q : v_wrap ? '0 : v_q + 10'd1;
    fc_d   = fc_q + {7'd0, h_wrap && v_wrap};
    hs_d   = hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d   = vs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
      hs_q <= ~SYNC_ACTIVE;
      vs_q <= ~SYNC_ACTIVE;
    end else if (pix_en) begin
      h_q  <= h_d;
      v_q  <= v_d;
      fc_q <= fc_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign hpos        = h_q;
  assign vpos        = v_q;
  assign frame_count = fc_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign display_on  = int'(h_q) < H_DISPLAY && int'(v_q) < V_DISPLAY;
  assign line_start  = pix_en && h_q == '0;
  assign frame_start = line_start && v_q == '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size instance for line timing, shrunken instance
// (active-high syncs) for frame-level behaviour, both against an arithmetic model.
module tb_vga_timing_gen;
  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] d_h, d_v, s_h, s_v;
  logic [7:0] d_fc, s_fc;
  logic d_de, d_hs, d_vs, d_ls, d_fs, s_de, s_hs, s_vs, s_ls, s_fs;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hpos(d_h), .vpos(d_v),
    .display_on(d_de), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b1)
  ) sdut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hpos(s_h), .vpos(s_v),
    .display_on(s_de), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    int h, v, fc;
    bit de, ls, fs, hs, vs;
  } exp_t;

  typedef struct {
    bit r, en;
    int h, v;
    bit ls, fs, hs;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  longint n = 0;
  bit valid = 1'b0;

  // the whole raster state is a function of advances since reset
  always @(posedge clk) begin
    if (!rst_n) begin
      n     <= 0;
      valid <= 1'b1;
    end else if (pix_en) n <= n + 1;
  end

  function automatic exp_t model(longint k, bit en, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb, bit act);
    exp_t e;
    int ht = hd + hf + hsw + hb, vt = vd + vf + vsw + vb, ph, pv;
    e.h  = int'(k % ht);
    e.v  = int'((k / ht) % vt);
    e.fc = int'((k / (ht * vt)) % 256);
    e.de = e.h < hd && e.v < vd;
    e.ls = en && e.h == 0;
    e.fs = e.ls && e.v == 0;
    e.hs = ~act;
    e.vs = ~act;
    if (k > 0) begin
      ph = int'((k - 1) % ht);
      pv = int'(((k - 1) / ht) % vt);
      e.hs = (ph >= hd + hf && ph < hd + hf + hsw) ? act : ~act;
      e.vs = (pv >= vd + vf && pv < vd + vf + vsw) ? act : ~act;
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    exp_t e;
    if (!valid) return;
    e = model(n, pix_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    chk("d_hpos", 32'(d_h), e.h);   chk("d_vpos", 32'(d_v), e.v);
    chk("d_fc", 32'(d_fc), e.fc);   chk("d_de", 32'(d_de), 32'(e.de));
    chk("d_ls", 32'(d_ls), 32'(e.ls)); chk("d_fs", 32'(d_fs), 32'(e.fs));
    chk("d_hsync", 32'(d_hs), 32'(e.hs)); chk("d_vsync", 32'(d_vs), 32'(e.vs));
    e = model(n, pix_en, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1);
    chk("s_hpos", 32'(s_h), e.h);   chk("s_vpos", 32'(s_v), e.v);
    chk("s_fc", 32'(s_fc), e.fc);   chk("s_de", 32'(s_de), 32'(e.de));
    chk("s_ls", 32'(s_ls), 32'(e.ls)); chk("s_fs", 32'(s_fs), 32'(e.fs));
    chk("s_hsync", 32'(s_hs), 32'(e.hs)); chk("s_vsync", 32'(s_vs), 32'(e.vs));
  endtask

  task automatic cyc(bit r, bit en);
    @(negedge clk);
    rst_n  = r;
    pix_en = en;
    #1;
    check_model();
  endtask

  initial begin
    vec_t tbl[8];
    int ls_cnt, fs_cnt, hs_lo, first_lo, de_cnt, vs_cnt, first_vs, h0;
    bit found;
    tbl[0] = '{1, 1, 0, 0, 1, 1, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 2, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 3, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 1, 1, 0};
    tbl[7] = '{1, 1, 1, 0, 0, 0, 0};

    cyc(0, 0);
    cyc(0, 1);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].en);
      chk("tbl_h", 32'(s_h), tbl[i].h);
      chk("tbl_v", 32'(s_v), tbl[i].v);
      chk("tbl_ls", 32'(s_ls), 32'(tbl[i].ls));
      chk("tbl_fs", 32'(s_fs), 32'(tbl[i].fs));
      chk("tbl_hs", 32'(s_hs), 32'(tbl[i].hs));
    end

    // one full line on the 640x480 instance
    cyc(0, 1);
    ls_cnt = 0; fs_cnt = 0; hs_lo = 0; first_lo = -1;
    for (int i = 0; i <= 800; i++) begin
      cyc(1, 1);
      if (i == 0) begin
        chk("rst_hsync_high", 32'(d_hs), 1);
        chk("rst_vsync_high", 32'(d_vs), 1);
      end
      ls_cnt += int'(d_ls);
      fs_cnt += int'(d_fs);
      if (i < 800 && d_hs == 1'b0) begin
        hs_lo++;
        if (first_lo < 0) first_lo = int'(d_h);
      end
      if (i == 800) begin
        chk("line_wrap_h", 32'(d_h), 0);
        chk("line_wrap_v", 32'(d_v), 1);
      end
    end
    chk("line_start_count", 32'(ls_cnt), 2);
    chk("frame_start_count", 32'(fs_cnt), 1);
    chk("hsync_width", 32'(hs_lo), 96);
    chk("hsync_first_low_hpos", 32'(first_lo), 657);

    // alternating pix_en halves the advance rate
    cyc(0, 0);
    cyc(1, 0);
    h0 = int'(d_h);
    ls_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, i % 2 == 0);
      if (i % 2 == 1) ls_cnt += int'(d_ls);
    end
    cyc(1, 0);
    chk("toggle_advance", 32'(d_h), h0 + 20);
    chk("toggle_no_ls", 32'(ls_cnt), 0);

    // one full frame on the small instance
    cyc(0, 1);
    de_cnt = 0; vs_cnt = 0; first_vs = -1;
    for (int i = 0; i < 150; i++) begin
      cyc(1, 1);
      de_cnt += int'(s_de);
      if (s_vs) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = i;
      end
    end
    chk("frame_de_count", 32'(de_cnt), 48);
    chk("frame_vsync_count", 32'(vs_cnt), 30);
    chk("frame_vsync_first", 32'(first_vs), 106);
    cyc(1, 1);
    chk("frame_restart_fs", 32'(s_fs), 1);
    chk("frame_count_one", 32'(s_fc), 1);

    // reset while both syncs are asserted mid-frame
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1, 1);
      found = s_h == 10'd12 && s_v == 10'd7;
    end
    chk("midframe_reached", 32'(found), 1);
    chk("midframe_hs_active", 32'(s_hs), 1);
    chk("midframe_vs_active", 32'(s_vs), 1);
    chk("midframe_fc", 32'(s_fc), 1);
    cyc(0, 1);
    cyc(1, 0);
    chk("post_rst_h", 32'(s_h), 0);
    chk("post_rst_v", 32'(s_v), 0);
    chk("post_rst_hs", 32'(s_hs), 0);
    chk("post_rst_vs", 32'(s_vs), 0);
    chk("post_rst_fc", 32'(s_fc), 0);
    chk("post_rst_d_hs", 32'(d_hs), 1);
    chk("post_rst_d_vs", 32'(d_vs), 1);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) != 0, 1'($urandom_range(0, 1)));

    // frame counter wrap after 256 small frames
    cyc(0, 1);
    for (int i = 0; i < 255 * 150; i++) cyc(1, 1);
    cyc(1, 1);
    chk("fc_255", 32'(s_fc), 255);
    for (int i = 0; i < 149; i++) cyc(1, 1);
    cyc(1, 1);
    chk("fc_wrap_0", 32'(s_fc), 0);
    chk("fc_wrap_fs", 32'(s_fs), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
